// File: rtl/fadd_pkg.sv
// Shared constants, types and flag helper for the FP adder result path.
package fadd_pkg;

    // IEEE-754 binary64 field layout
    localparam int DBL_EXP_LSB  = 52;
    localparam int DBL_EXP_W    = 11;
    localparam int DBL_FRAC_LSB = 0;
    localparam int DBL_FRAC_W   = 52;

    // IEEE-754 binary32 field layout (within one 32-bit lane)
    localparam int SGL_EXP_LSB  = 23;
    localparam int SGL_EXP_W    = 8;
    localparam int SGL_FRAC_LSB = 0;
    localparam int SGL_FRAC_W   = 23;

    // Packed-lane offsets inside the 64-bit result word
    localparam int LANE_W    = 32;
    localparam int LANE0_LSB = 0;
    localparam int LANE1_LSB = 32;

    // Classification flag bit indices
    localparam int FLAG_W    = 3;
    localparam int FLAG_NAN  = 2;
    localparam int FLAG_INF  = 1;
    localparam int FLAG_ZERO = 0;

    // One buffered result word
    typedef struct packed {
        logic       mode;   // 1 = double, 0 = two singles
        logic [1:0] mask;   // enabled single lanes
        logic [63:0] res;   // packed result
    } word_t;

    localparam word_t WORD_RST = {1'b0, 2'b00, 64'h0000_0000_0000_0000};

    // Build {nan, inf, zero} from exponent/fraction summary bits
    function automatic logic [FLAG_W-1:0] make_flags(
        input logic exp_ones,
        input logic exp_zero,
        input logic frac_zero
    );
        logic [FLAG_W-1:0] f;
        f            = {FLAG_W{1'b0}};
        f[FLAG_NAN]  = exp_ones & ~frac_zero;
        f[FLAG_INF]  = exp_ones &  frac_zero;
        f[FLAG_ZERO] = exp_zero &  frac_zero;
        return f;
    endfunction

endpackage

// File: rtl/fadd_result_unpack_if.sv
// Handshake bundle between the adder result bus and the scalar beat stream.
interface fadd_result_unpack_if
    import fadd_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    // Word side (from the adder)
    logic              i_valid;
    logic              o_ready;
    logic              i_mode;
    logic [1:0]        i_lane_mask;
    logic [63:0]       i_res;

    // Beat side (to the consumer)
    logic              o_valid;
    logic              i_ready;
    logic [63:0]       o_data;
    logic              o_is_double;
    logic              o_lane;
    logic              o_last;
    logic [FLAG_W-1:0] o_flags;
    logic [CW-1:0]     o_count;

    // Unpacker view
    modport slave (
        input  i_valid, i_mode, i_lane_mask, i_res, i_ready,
        output o_ready, o_valid, o_data, o_is_double, o_lane, o_last, o_flags, o_count
    );

    // Producer/consumer view
    modport master (
        output i_valid, i_mode, i_lane_mask, i_res, i_ready,
        input  o_ready, o_valid, o_data, o_is_double, o_lane, o_last, o_flags, o_count
    );

endinterface

// File: rtl/fadd_fp_class.sv
// Combinational NaN/Inf/zero classifier for one beat value (double or single lane).
module fadd_fp_class
    import fadd_pkg::*;
(
    input  logic              i_is_double,
    input  logic [63:0]       i_val,
    output logic [FLAG_W-1:0] o_flags
);

    logic [DBL_EXP_W-1:0]  dbl_exp_s;
    logic [DBL_FRAC_W-1:0] dbl_frac_s;
    logic [SGL_EXP_W-1:0]  sgl_exp_s;
    logic [SGL_FRAC_W-1:0] sgl_frac_s;
    logic                  exp_ones_s;
    logic                  exp_zero_s;
    logic                  frac_zero_s;
    logic                  sign_unused_s;

    assign dbl_exp_s  = i_val[DBL_EXP_LSB +: DBL_EXP_W];
    assign dbl_frac_s = i_val[DBL_FRAC_LSB +: DBL_FRAC_W];
    assign sgl_exp_s  = i_val[SGL_EXP_LSB +: SGL_EXP_W];
    assign sgl_frac_s = i_val[SGL_FRAC_LSB +: SGL_FRAC_W];

    // Sign bits play no part in classification (zero of either sign is zero)
    assign sign_unused_s = i_val[63] ^ i_val[31];

    // Pick the field set matching the beat format and summarise it
    always_comb begin
        exp_ones_s  = 1'b0;
        exp_zero_s  = 1'b0;
        frac_zero_s = 1'b0;
        if (i_is_double) begin
            exp_ones_s  = &dbl_exp_s;
            exp_zero_s  = ~|dbl_exp_s;
            frac_zero_s = ~|dbl_frac_s;
        end else begin
            exp_ones_s  = &sgl_exp_s;
            exp_zero_s  = ~|sgl_exp_s;
            frac_zero_s = ~|sgl_frac_s;
        end
        o_flags = make_flags(exp_ones_s, exp_zero_s, frac_zero_s);
    end

endmodule

// File: rtl/fadd_result_unpack.sv
// Buffers packed adder result words in a small FIFO and emits them as
// scalar beats (one per double, one per enabled single lane) with flags.
module fadd_result_unpack
    import fadd_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                 i_clk,
    input  logic                 i_clr,
    fadd_result_unpack_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Storage and control state
    word_t             mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              lp_q, lp_d;

    // Combinational helpers
    word_t             head_s;
    logic              full_s;
    logic              empty_s;
    logic              store_s;
    logic              push_s;
    logic              beat_s;
    logic              pop_s;
    logic              lane_s;
    logic              last_s;
    logic [63:0]       beat_val_s;
    logic [FLAG_W-1:0] class_flags_s;

    assign head_s  = mem_q[rd_ptr_q];
    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});

    // Handshake decode: empty-mask single words are accepted but dropped
    always_comb begin
        store_s = bus.i_mode | (bus.i_lane_mask != 2'b00);
        push_s  = bus.i_valid & ~full_s & store_s;
        beat_s  = ~empty_s & bus.i_ready;
        pop_s   = beat_s & last_s;
    end

    // Current lane and last-beat decode for the head word. lp_q counts beats
    // already sent; only a mask-11 word has a second beat, and a mask-10 word
    // starts directly on lane 1, so lp_q is the lane index only for mask 11.
    always_comb begin
        lane_s = 1'b0;
        last_s = 1'b1;
        if (head_s.mode) begin
            lane_s = 1'b0;
            last_s = 1'b1;
        end else begin
            case (head_s.mask)
                2'b11: begin
                    lane_s = lp_q;
                    last_s = lp_q;
                end
                2'b10: begin
                    lane_s = 1'b1;
                    last_s = 1'b1;
                end
                2'b01: begin
                    lane_s = 1'b0;
                    last_s = 1'b1;
                end
                default: begin
                    lane_s = 1'b0;
                    last_s = 1'b1;
                end
            endcase
        end
    end

    // Beat value selection; zero when nothing is held
    always_comb begin
        beat_val_s = 64'h0000_0000_0000_0000;
        if (empty_s) begin
            beat_val_s = 64'h0000_0000_0000_0000;
        end else if (head_s.mode) begin
            beat_val_s = head_s.res;
        end else if (lane_s) begin
            beat_val_s = {32'h0000_0000, head_s.res[LANE1_LSB +: LANE_W]};
        end else begin
            beat_val_s = {32'h0000_0000, head_s.res[LANE0_LSB +: LANE_W]};
        end
    end

    fadd_fp_class u_class (
        .i_is_double (head_s.mode),
        .i_val       (beat_val_s),
        .o_flags     (class_flags_s)
    );

    // Next-state for pointers, occupancy and lane pointer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lp_d     = lp_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            lp_d     = 1'b0;
        end else if (beat_s) begin
            rd_ptr_d = rd_ptr_q;
            lp_d     = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
            lp_d     = lp_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // Control state register
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            lp_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lp_q     <= lp_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WORD_RST;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.i_mode, bus.i_lane_mask, bus.i_res};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Outputs depend only on registered state, so i_ready never reaches o_ready
    assign bus.o_ready     = ~full_s;
    assign bus.o_valid     = ~empty_s;
    assign bus.o_data      = beat_val_s;
    assign bus.o_is_double = ~empty_s & head_s.mode;
    assign bus.o_lane      = ~empty_s & ~head_s.mode & lane_s;
    assign bus.o_last      = ~empty_s & last_s;
    assign bus.o_flags     = empty_s ? {FLAG_W{1'b0}} : class_flags_s;
    assign bus.o_count     = count_q;

endmodule
